// File: rtl/sa_pkg.sv
// Shared defaults, FSM state type and matrix container for the systolic GEMM block.
package sa_pkg;

  localparam int SA_SIZE    = 4;
  localparam int SA_X_WIDTH = 8;
  localparam int SA_Y_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FEED  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_OUT   = 2'd3
  } sa_state_e;

  typedef struct packed {
    logic [SA_SIZE-1:0][SA_SIZE-1:0][SA_Y_WIDTH-1:0] elem;
  } matrix_t;

  // Cycle counter width covering the full FEED+DRAIN window of 3*size cycles.
  function automatic int cnt_width(input int size);
    return $clog2(3 * size);
  endfunction

endpackage

// File: rtl/sa_pe.sv
// Weight-stationary MAC cell: holds one B element, forwards A to the right and
// adds its product into the partial sum travelling down the column.
module sa_pe
  import sa_pkg::*;
#(
  parameter int X_WIDTH = SA_X_WIDTH,
  parameter int Y_WIDTH = SA_Y_WIDTH,
  parameter int SIGNED  = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               w_we_i,
  input  logic [X_WIDTH-1:0] w_i,
  input  logic [X_WIDTH-1:0] a_i,
  input  logic [Y_WIDTH-1:0] psum_i,
  output logic [X_WIDTH-1:0] a_o,
  output logic [Y_WIDTH-1:0] psum_o
);

  logic [X_WIDTH-1:0]   w_q;
  logic [X_WIDTH-1:0]   a_q;
  logic [Y_WIDTH-1:0]   psum_q;
  logic [2*X_WIDTH-1:0] a_ext;
  logic [2*X_WIDTH-1:0] w_ext;
  logic [2*X_WIDTH-1:0] prod;
  logic [Y_WIDTH-1:0]   prod_ext;

  // Extending both operands to the product width keeps the low bits exact for
  // two's-complement as well as unsigned multiplication.
  if (SIGNED != 0) begin : g_signed
    assign a_ext    = {{X_WIDTH{a_i[X_WIDTH-1]}}, a_i};
    assign w_ext    = {{X_WIDTH{w_q[X_WIDTH-1]}}, w_q};
    assign prod_ext = {{(Y_WIDTH-2*X_WIDTH){prod[2*X_WIDTH-1]}}, prod};
  end else begin : g_unsigned
    assign a_ext    = {{X_WIDTH{1'b0}}, a_i};
    assign w_ext    = {{X_WIDTH{1'b0}}, w_q};
    assign prod_ext = {{(Y_WIDTH-2*X_WIDTH){1'b0}}, prod};
  end

  assign prod = a_ext * w_ext;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_q    <= '0;
      a_q    <= '0;
      psum_q <= '0;
    end else begin
      if (w_we_i) begin
        w_q <= w_i;
      end
      a_q    <= a_i;
      psum_q <= psum_i + prod_ext;
    end
  end

  assign a_o    = a_q;
  assign psum_o = psum_q;

endmodule

// File: rtl/sa_gemm.sv
// SIZE x SIZE weight-stationary systolic array computing C = A*B (optionally
// accumulated into the previous C), with an IDLE/FEED/DRAIN/OUT control FSM.
module sa_gemm
  import sa_pkg::*;
#(
  parameter int SIZE    = SA_SIZE,
  parameter int X_WIDTH = SA_X_WIDTH,
  parameter int Y_WIDTH = SA_Y_WIDTH,
  parameter int SIGNED  = 0
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   i_we,
  input  logic [SIZE-1:0][SIZE-1:0][X_WIDTH-1:0] i_weights,
  input  logic                                   i_matrix_vld,
  output logic                                   o_matrix_rdy,
  input  logic [SIZE-1:0][SIZE-1:0][X_WIDTH-1:0] i_matrix,
  input  logic                                   i_acc,
  output logic                                   o_matrix_vld,
  input  logic                                   i_res_rdy,
  output logic [SIZE-1:0][SIZE-1:0][Y_WIDTH-1:0] o_matrix,
  output logic                                   o_busy,
  output logic [1:0]                             o_dbg_state
);

  localparam int            CW         = cnt_width(SIZE);
  localparam logic [CW-1:0] FEED_LAST  = CW'(2*SIZE-2);
  localparam logic [CW-1:0] DRAIN_LAST = CW'(3*SIZE-1);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; A is accepted only in IDLE, C is released only from OUT.

  sa_state_e                              state_q;
  logic [CW-1:0]                          cnt_q;
  logic                                   acc_q;
  logic                                   rdy_q;
  logic                                   busy_q;
  logic                                   vld_q;
  logic [SIZE-1:0][SIZE-1:0][X_WIDTH-1:0] a_q;
  logic [SIZE-1:0][SIZE-1:0][Y_WIDTH-1:0] res_q;
  logic [SIZE-1:0][SIZE-1:0][Y_WIDTH-1:0] res_d;

  logic                                   w_we;
  logic                                   accept;
  logic [X_WIDTH-1:0]                     feed   [SIZE];
  logic [X_WIDTH-1:0]                     a_link [SIZE][SIZE+1];
  logic [Y_WIDTH-1:0]                     p_link [SIZE+1][SIZE];

  assign w_we   = (state_q == ST_IDLE) && i_we;
  assign accept = (state_q == ST_IDLE) && rdy_q && i_matrix_vld;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      acc_q   <= 1'b0;
      rdy_q   <= 1'b0;
      busy_q  <= 1'b0;
      vld_q   <= 1'b0;
      a_q     <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            state_q <= ST_FEED;
            cnt_q   <= '0;
            a_q     <= i_matrix;
            acc_q   <= i_acc;
            rdy_q   <= 1'b0;
            busy_q  <= 1'b1;
          end else begin
            rdy_q <= 1'b1;
          end
        end
        ST_FEED: begin
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == FEED_LAST) begin
            state_q <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == DRAIN_LAST) begin
            state_q <= ST_OUT;
            vld_q   <= 1'b1;
          end
        end
        ST_OUT: begin
          if (i_res_rdy) begin
            state_q <= ST_IDLE;
            vld_q   <= 1'b0;
            busy_q  <= 1'b0;
            rdy_q   <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Array row k sees column k of A, element r arriving at cycle r+k (skew).
  always_comb begin
    for (int k = 0; k < SIZE; k++) begin
      feed[k] = '0;
      if (state_q == ST_FEED) begin
        for (int r = 0; r < SIZE; r++) begin
          if (cnt_q == CW'(r + k)) begin
            feed[k] = a_q[r][k];
          end
        end
      end
    end
  end

  for (genvar k = 0; k < SIZE; k++) begin : g_row
    assign a_link[k][0] = feed[k];
    for (genvar j = 0; j < SIZE; j++) begin : g_col
      sa_pe #(
        .X_WIDTH (X_WIDTH),
        .Y_WIDTH (Y_WIDTH),
        .SIGNED  (SIGNED)
      ) u_pe (
        .clk     (clk),
        .rst     (rst),
        .w_we_i  (w_we),
        .w_i     (i_weights[k][j]),
        .a_i     (a_link[k][j]),
        .psum_i  (p_link[k][j]),
        .a_o     (a_link[k][j+1]),
        .psum_o  (p_link[k+1][j])
      );
    end
  end

  for (genvar j = 0; j < SIZE; j++) begin : g_top
    assign p_link[0][j] = '0;
  end

  // C[i][j] leaves the bottom of column j while the counter reads i+j+SIZE (deskew).
  always_comb begin
    res_d = res_q;
    if ((state_q == ST_FEED) || (state_q == ST_DRAIN)) begin
      for (int i = 0; i < SIZE; i++) begin
        for (int j = 0; j < SIZE; j++) begin
          if (cnt_q == CW'(i + j + SIZE)) begin
            res_d[i][j] = acc_q ? (res_q[i][j] + p_link[SIZE][j]) : p_link[SIZE][j];
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_q <= '0;
    end else begin
      res_q <= res_d;
    end
  end

  assign o_matrix     = res_q;
  assign o_matrix_vld = vld_q;
  assign o_matrix_rdy = rdy_q;
  assign o_busy       = busy_q;
  assign o_dbg_state  = state_q;

endmodule

// File: tb/tb_sa_gemm.sv
// Bench for sa_gemm: an unsigned and a signed instance share all stimulus and
// are checked against a plain-arithmetic matrix-product model.
module tb_sa_gemm;

  localparam int S  = 4;
  localparam int XW = 8;
  localparam int YW = 32;

  typedef logic [S-1:0][S-1:0][XW-1:0] xmat_t;
  typedef logic [S-1:0][S-1:0][YW-1:0] ymat_t;

  logic  clk = 1'b0;
  logic  rst = 1'b1;
  logic  i_we = 1'b0;
  logic  i_matrix_vld = 1'b0;
  logic  i_acc = 1'b0;
  logic  i_res_rdy = 1'b0;
  xmat_t i_weights = '0;
  xmat_t i_matrix = '0;

  logic  rdy_u, vld_u, busy_u, rdy_s, vld_s, busy_s;
  ymat_t c_u, c_s;
  logic [1:0] st_u, st_s;

  int checks = 0;
  int errors = 0;

  xmat_t b_model = '0;
  ymat_t res_u_m = '0;
  ymat_t res_s_m = '0;

  sa_gemm #(.SIZE(S), .X_WIDTH(XW), .Y_WIDTH(YW), .SIGNED(0)) u_dut_u (
    .clk(clk), .rst(rst), .i_we(i_we), .i_weights(i_weights),
    .i_matrix_vld(i_matrix_vld), .o_matrix_rdy(rdy_u), .i_matrix(i_matrix),
    .i_acc(i_acc), .o_matrix_vld(vld_u), .i_res_rdy(i_res_rdy),
    .o_matrix(c_u), .o_busy(busy_u), .o_dbg_state(st_u)
  );

  sa_gemm #(.SIZE(S), .X_WIDTH(XW), .Y_WIDTH(YW), .SIGNED(1)) u_dut_s (
    .clk(clk), .rst(rst), .i_we(i_we), .i_weights(i_weights),
    .i_matrix_vld(i_matrix_vld), .o_matrix_rdy(rdy_s), .i_matrix(i_matrix),
    .i_acc(i_acc), .o_matrix_vld(vld_s), .i_res_rdy(i_res_rdy),
    .o_matrix(c_s), .o_busy(busy_s), .o_dbg_state(st_s)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic ymat_t gemm(input xmat_t a, input xmat_t b, input bit sgn,
                                 input ymat_t prev, input bit acc);
    ymat_t c;
    logic [YW-1:0] s;
    longint pa, pb;
    for (int i = 0; i < S; i++) begin
      for (int j = 0; j < S; j++) begin
        s = acc ? prev[i][j] : '0;
        for (int k = 0; k < S; k++) begin
          if (sgn) begin
            pa = longint'($signed(a[i][k]));
            pb = longint'($signed(b[k][j]));
          end else begin
            pa = longint'(a[i][k]);
            pb = longint'(b[k][j]);
          end
          s = s + YW'(pa * pb);
        end
        c[i][j] = s;
      end
    end
    return c;
  endfunction

  function automatic xmat_t rand_xmat();
    xmat_t m;
    for (int i = 0; i < S; i++)
      for (int j = 0; j < S; j++)
        case ($urandom_range(0, 3))
          0:       m[i][j] = 8'hFF;
          1:       m[i][j] = 8'h80;
          default: m[i][j] = XW'($urandom_range(0, 255));
        endcase
    return m;
  endfunction

  function automatic xmat_t fill_xmat(input logic [XW-1:0] v);
    xmat_t m;
    for (int i = 0; i < S; i++)
      for (int j = 0; j < S; j++)
        m[i][j] = v;
    return m;
  endfunction

  function automatic xmat_t ident_xmat();
    xmat_t m;
    for (int i = 0; i < S; i++)
      for (int j = 0; j < S; j++)
        m[i][j] = (i == j) ? 8'd1 : 8'd0;
    return m;
  endfunction

  // ---------------- driver: one complete operation ----------------
  task automatic do_op(input string name, input xmat_t a, input bit load_w,
                       input xmat_t w, input bit acc, input int hold);
    int    lat;
    bit    ok;
    ymat_t snap_u, snap_s;
    lat = 0;
    while (!(rdy_u === 1'b1 && rdy_s === 1'b1) && lat < 50) begin
      @(posedge clk); @(negedge clk); lat++;
    end
    checks++;
    if (!(rdy_u === 1'b1 && rdy_s === 1'b1)) begin
      errors++;
      $display("FAIL %s ready_wait: rdy_u=%b rdy_s=%b required 1", name, rdy_u, rdy_s);
    end
    i_matrix = a; i_acc = acc; i_we = load_w; i_weights = w; i_matrix_vld = 1'b1;
    @(posedge clk); @(negedge clk);
    i_matrix_vld = 1'b0; i_we = 1'b0; i_acc = ~acc;
    i_matrix = rand_xmat(); i_weights = rand_xmat();
    if (load_w) b_model = w;
    res_u_m = gemm(a, b_model, 1'b0, res_u_m, acc);
    res_s_m = gemm(a, b_model, 1'b1, res_s_m, acc);
    checks++;
    if (busy_u !== 1'b1 || busy_s !== 1'b1 || rdy_u !== 1'b0 || rdy_s !== 1'b0 ||
        vld_u !== 1'b0 || vld_s !== 1'b0) begin
      errors++;
      $display("FAIL %s accept_flags: busy=%b%b rdy=%b%b vld=%b%b required busy=11 rdy=00 vld=00",
               name, busy_u, busy_s, rdy_u, rdy_s, vld_u, vld_s);
    end
    lat = 0;
    while (vld_u !== 1'b1 && lat < 60) begin
      @(posedge clk); lat++; @(negedge clk);
    end
    checks++;
    if (lat != 3 * S || vld_s !== 1'b1) begin
      errors++;
      $display("FAIL %s latency: got %0d cycles (vld_s=%b) required %0d", name, lat, vld_s, 3 * S);
    end
    checks++;
    if (c_u !== res_u_m) begin
      errors++;
      $display("FAIL %s result_unsigned: got %h required %h", name, c_u, res_u_m);
    end
    checks++;
    if (c_s !== res_s_m) begin
      errors++;
      $display("FAIL %s result_signed: got %h required %h", name, c_s, res_s_m);
    end
    if (hold > 0) begin
      snap_u = c_u; snap_s = c_s; ok = 1'b1;
      for (int h = 0; h < hold; h++) begin
        i_matrix_vld = 1'b1; i_matrix = rand_xmat();
        i_we = 1'b1; i_weights = rand_xmat();
        @(posedge clk); @(negedge clk);
        if (c_u !== snap_u || c_s !== snap_s || vld_u !== 1'b1 || vld_s !== 1'b1 ||
            rdy_u !== 1'b0 || rdy_s !== 1'b0 || busy_u !== 1'b1 || busy_s !== 1'b1)
          ok = 1'b0;
      end
      i_matrix_vld = 1'b0; i_we = 1'b0;
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL %s hold_stable: outputs changed or A accepted during OUT hold, required stable", name);
      end
    end
    i_res_rdy = 1'b1;
    @(posedge clk); @(negedge clk);
    i_res_rdy = 1'b0;
    checks++;
    if (vld_u !== 1'b0 || vld_s !== 1'b0 || busy_u !== 1'b0 || busy_s !== 1'b0 ||
        rdy_u !== 1'b1 || rdy_s !== 1'b1) begin
      errors++;
      $display("FAIL %s release: vld=%b%b busy=%b%b rdy=%b%b required vld=00 busy=00 rdy=11",
               name, vld_u, vld_s, busy_u, busy_s, rdy_u, rdy_s);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (vld_u !== 1'b0 || vld_s !== 1'b0 || busy_u !== 1'b0 || busy_s !== 1'b0 ||
        c_u !== '0 || c_s !== '0) begin
      errors++;
      $display("FAIL reset_during: vld=%b%b busy=%b%b c_u=%h required all zero",
               vld_u, vld_s, busy_u, busy_s, c_u);
    end
    rst = 1'b0;
    @(posedge clk); @(negedge clk);
    checks++;
    if (rdy_u !== 1'b1 || rdy_s !== 1'b1 || busy_u !== 1'b0 || vld_u !== 1'b0 ||
        st_u !== st_s) begin
      errors++;
      $display("FAIL reset_after: rdy=%b%b busy=%b vld=%b st=%0d/%0d required rdy=11 busy=0 vld=0 equal states",
               rdy_u, rdy_s, busy_u, vld_u, st_u, st_s);
    end
  endtask

  task automatic test_identity();
    xmat_t a;
    bit ok;
    for (int i = 0; i < S; i++)
      for (int j = 0; j < S; j++)
        a[i][j] = XW'(i * S + j);
    do_op("identity", a, 1'b1, ident_xmat(), 1'b0, 0);
    ok = 1'b1;
    for (int i = 0; i < S; i++)
      for (int j = 0; j < S; j++)
        if (c_u[i][j] !== YW'(i * S + j)) ok = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL identity_c_eq_a: got %h required C equal to A", c_u);
    end
  endtask

  task automatic test_all_ff();
    bit ok;
    do_op("all_ff", fill_xmat(8'hFF), 1'b1, fill_xmat(8'hFF), 1'b0, 0);
    ok = 1'b1;
    for (int i = 0; i < S; i++)
      for (int j = 0; j < S; j++)
        if (c_u[i][j] !== 32'h0003_F804) ok = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL all_ff_unsigned: got %h required every element 0003f804", c_u);
    end
  endtask

  task automatic test_signed();
    bit ok;
    do_op("signed", fill_xmat(8'hFF), 1'b1, fill_xmat(8'h02), 1'b0, 0);
    ok = 1'b1;
    for (int i = 0; i < S; i++)
      for (int j = 0; j < S; j++)
        if (c_s[i][j] !== 32'hFFFF_FFF8) ok = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL signed_minus8: got %h required every element fffffff8", c_s);
    end
  endtask

  task automatic test_accumulate();
    bit ok;
    do_op("acc_first", fill_xmat(8'h01), 1'b1, ident_xmat(), 1'b0, 0);
    do_op("acc_second", fill_xmat(8'h01), 1'b0, rand_xmat(), 1'b1, 0);
    ok = 1'b1;
    for (int i = 0; i < S; i++)
      for (int j = 0; j < S; j++)
        if (c_u[i][j] !== 32'd2 || c_s[i][j] !== 32'd2) ok = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL accumulate_twos: got %h required every element 2", c_u);
    end
  endtask

  task automatic test_hold();
    do_op("hold", rand_xmat(), 1'b1, rand_xmat(), 1'b0, 20);
    // Weights driven during the hold must not have been taken.
    do_op("after_hold", rand_xmat(), 1'b0, rand_xmat(), 1'b0, 0);
  endtask

  task automatic test_reset_mid_feed();
    bit ok;
    i_matrix = rand_xmat(); i_weights = rand_xmat(); i_we = 1'b1; i_acc = 1'b0;
    i_matrix_vld = 1'b1;
    @(posedge clk); @(negedge clk);
    i_matrix_vld = 1'b0; i_we = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    checks++;
    if (vld_u !== 1'b0 || vld_s !== 1'b0 || busy_u !== 1'b0 || busy_s !== 1'b0 ||
        c_u !== '0 || c_s !== '0) begin
      errors++;
      $display("FAIL midfeed_reset_state: vld=%b%b busy=%b%b c_u=%h required all zero",
               vld_u, vld_s, busy_u, busy_s, c_u);
    end
    rst = 1'b0;
    b_model = '0; res_u_m = '0; res_s_m = '0;
    ok = 1'b1;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk); @(negedge clk);
      if (vld_u !== 1'b0 || vld_s !== 1'b0 || busy_u !== 1'b0 || c_u !== '0) ok = 1'b0;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL midfeed_no_result: vld=%b%b busy=%b required no result after aborted op",
               vld_u, vld_s, busy_u);
    end
    do_op("after_reset", rand_xmat(), 1'b1, rand_xmat(), 1'b1, 0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 10; n++)
      do_op("random", rand_xmat(), 1'($urandom_range(0, 1)), rand_xmat(),
            1'($urandom_range(0, 1)), $urandom_range(0, 1) * $urandom_range(1, 5));
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 4; n++)
      do_op("back_to_back", rand_xmat(), 1'b1, rand_xmat(), 1'($urandom_range(0, 1)), 0);
  endtask

  initial begin
    test_reset();
    test_identity();
    test_all_ff();
    test_signed();
    test_accumulate();
    test_hold();
    test_reset_mid_feed();
    test_random();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
